// File: rtl/exp_pkg.sv
// exp_pkg: shared types and helpers for the CP0 exception source controller.
//   NSRC_DEFAULT : default number of interrupt sources (matches CP0 ExpSrc width)
//   MAX_SRC      : widest request vector the priority selector accepts
//   exp_state_e  : controller FSM states
//   prio_sel_t   : priority-select result (valid bit plus winning index)
//   prio_select  : picks the highest set index of a request vector
package exp_pkg;

    localparam int unsigned NSRC_DEFAULT = 3;
    localparam int unsigned MAX_SRC      = 32;
    localparam int unsigned IDX_W        = $clog2(MAX_SRC);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } exp_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_sel_t;

    // Highest index wins: the loop runs upward so later hits overwrite earlier ones.
    function automatic prio_sel_t prio_select(input logic [MAX_SRC-1:0] req);
        prio_sel_t res;
        res = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (req[i]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchroniser plus rising-edge detector for one interrupt line.
//   clk      : system clock
//   rst      : synchronous active-high reset, clears every flop
//   irq_in   : asynchronous level interrupt line
//   irq_edge : high for one cycle when the synchronised line goes 0 -> 1
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic irq_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Because prev also resets to 0, a line held high across reset gives one edge.
    assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exp_src_ctrl.sv
// exp_src_ctrl: upstream feeder for the CP0 exception unit.
//   clk, rst   : system clock, synchronous active-high reset
//   irq_in     : asynchronous interrupt lines (rising edges count)
//   mask       : 1 = source blocked; pending is kept but not presented
//   exp_ack    : CP0 took the exception (one-cycle pulse)
//   eret       : ERET retired (one-cycle pulse)
//   lost_clr   : clears the sticky lost flags
//   exp_src    : registered one-hot request to CP0, all-zero = none
//   cause_id   : index of the requested / in-service source
//   pending    : latched, not-yet-acknowledged edges
//   in_service : handler running
//   lost       : sticky, an edge arrived while that source was already pending
module exp_src_ctrl
    import exp_pkg::*;
#(
    parameter int unsigned NSRC        = NSRC_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         irq_in,
    input  logic [NSRC-1:0]         mask,
    input  logic                    exp_ack,
    input  logic                    eret,
    input  logic                    lost_clr,
    output logic [NSRC-1:0]         exp_src,
    output logic [$clog2(NSRC)-1:0] cause_id,
    output logic [NSRC-1:0]         pending,
    output logic                    in_service,
    output logic [NSRC-1:0]         lost
);

    localparam int unsigned CW = $clog2(NSRC);

    exp_state_e      state_q, state_d;
    logic [NSRC-1:0] exp_src_q, exp_src_d;
    logic [CW-1:0]   cause_id_q, cause_id_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] lost_q, lost_d;

    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] lost_set;
    prio_sel_t       sel;
    logic            unused_idx_hi;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .irq_in  (irq_in[g]),
            .irq_edge(edges[g])
        );
    end

    assign sel           = prio_select(MAX_SRC'(pending_q & ~mask));
    assign unused_idx_hi = ^sel.idx[IDX_W-1:CW];

    always_comb begin
        state_d    = state_q;
        exp_src_d  = exp_src_q;
        cause_id_d = cause_id_q;
        ack_clr    = '0;

        unique case (state_q)
            StIdle: begin
                if (sel.valid) begin
                    exp_src_d                  = '0;
                    exp_src_d[sel.idx[CW-1:0]] = 1'b1;
                    cause_id_d                 = sel.idx[CW-1:0];
                    state_d                    = StReq;
                end
            end
            StReq: begin
                // The source was unmasked on entry, so the first cycle its mask reads
                // high here is the rise; ack takes precedence over withdrawal.
                if (exp_ack) begin
                    ack_clr[cause_id_q] = 1'b1;
                    exp_src_d           = '0;
                    state_d             = StService;
                end else if (mask[cause_id_q]) begin
                    exp_src_d = '0;
                    state_d   = StIdle;
                end
            end
            StService: begin
                if (eret) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                exp_src_d = '0;
            end
        endcase

        // A fresh edge beats the ack clear, and is not counted as lost since the
        // old occurrence is being consumed in the same cycle.
        lost_set  = edges & pending_q & ~ack_clr;
        pending_d = (pending_q & ~ack_clr) | edges;
        lost_d    = (lost_clr ? '0 : lost_q) | lost_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            exp_src_q  <= '0;
            cause_id_q <= '0;
            pending_q  <= '0;
            lost_q     <= '0;
        end else begin
            state_q    <= state_d;
            exp_src_q  <= exp_src_d;
            cause_id_q <= cause_id_d;
            pending_q  <= pending_d;
            lost_q     <= lost_d;
        end
    end

    assign exp_src    = exp_src_q;
    assign cause_id   = cause_id_q;
    assign pending    = pending_q;
    assign lost       = lost_q;
    assign in_service = (state_q == StService);

endmodule

// File: tb/tb_exp_src_ctrl.sv
module tb_exp_src_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_in;
    logic [2:0] mask;
    logic       exp_ack;
    logic       eret;
    logic       lost_clr;
    logic [2:0] exp_src;
    logic [1:0] cause_id;
    logic [2:0] pending;
    logic       in_service;
    logic [2:0] lost;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] src;
        logic [1:0] id;
    } req_t;

    req_t exp_q[$];
    logic [2:0] prev_src = '0;

    exp_src_ctrl #(
        .NSRC       (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .exp_ack   (exp_ack),
        .eret      (eret),
        .lost_clr  (lost_clr),
        .exp_src   (exp_src),
        .cause_id  (cause_id),
        .pending   (pending),
        .in_service(in_service),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] src, input logic [1:0] id);
        req_t r;
        r.src = src;
        r.id  = id;
        exp_q.push_back(r);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        exp_ack = 1'b1;
        tick(1);
        exp_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    // Monitor: each new request (exp_src leaving zero) is matched against the scoreboard.
    always @(negedge clk) begin
        req_t r;
        if (exp_src != 3'b000 && prev_src == 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual=%b required=none at %0t", exp_src, $time);
            end else begin
                r = exp_q.pop_front();
                check("req_src", 32'(exp_src), 32'(r.src));
                check("req_cause", 32'(cause_id), 32'(r.id));
            end
        end else if (exp_src != 3'b000 && exp_src != prev_src) begin
            checks++;
            errors++;
            $display("FAIL req_stable actual=%b required=%b at %0t", exp_src, prev_src, $time);
        end
        prev_src = exp_src;
    end

    initial begin
        rst      = 1'b1;
        irq_in   = '0;
        mask     = '0;
        exp_ack  = 1'b0;
        eret     = 1'b0;
        lost_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_src", 32'(exp_src), 0);
        check("rst_cause", 32'(cause_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_lost", 32'(lost), 0);
        check("rst_insvc", 32'(in_service), 0);

        // Single source, exact latency, ack, eret.
        irq_in = 3'b001;
        push(3'b001, 2'd0);
        tick(3);
        check("t1_src_early", 32'(exp_src), 0);
        check("t1_pending", 32'(pending), 32'b001);
        tick(1);
        check("t1_src", 32'(exp_src), 32'b001);
        pulse_ack();
        check("t1_ack_src", 32'(exp_src), 0);
        check("t1_ack_insvc", 32'(in_service), 1);
        check("t1_ack_pending", 32'(pending), 0);
        irq_in = 3'b000;
        pulse_eret();
        check("t1_eret_insvc", 32'(in_service), 0);
        tick(3);

        // Two simultaneous edges: highest index first, the other after eret.
        irq_in = 3'b101;
        push(3'b100, 2'd2);
        push(3'b001, 2'd0);
        tick(4);
        check("t2_src", 32'(exp_src), 32'b100);
        pulse_ack();
        check("t2_pending", 32'(pending), 32'b001);
        check("t2_insvc", 32'(in_service), 1);
        pulse_eret();
        check("t2_eret_src", 32'(exp_src), 0);
        check("t2_eret_insvc", 32'(in_service), 0);
        tick(1);
        check("t2_second_src", 32'(exp_src), 32'b001);
        pulse_ack();
        pulse_eret();
        irq_in = 3'b000;
        tick(3);

        // No pre-emption by a higher-priority edge while in REQ.
        irq_in = 3'b001;
        push(3'b001, 2'd0);
        tick(4);
        irq_in = 3'b101;
        tick(4);
        check("t3_hold_src", 32'(exp_src), 32'b001);
        check("t3_pending", 32'(pending), 32'b101);
        push(3'b100, 2'd2);
        pulse_ack();
        pulse_eret();
        check("t3_eret_src", 32'(exp_src), 0);
        tick(1);
        check("t3_src2", 32'(exp_src), 32'b100);
        pulse_ack();
        pulse_eret();
        irq_in = 3'b000;
        tick(3);

        // Masking: blocked while masked, presented when unmasked, withdrawn on re-mask.
        mask   = 3'b010;
        irq_in = 3'b010;
        tick(4);
        check("t4_pending", 32'(pending), 32'b010);
        check("t4_masked_src", 32'(exp_src), 0);
        tick(5);
        check("t4_masked_src_late", 32'(exp_src), 0);
        push(3'b010, 2'd1);
        mask = 3'b000;
        tick(1);
        check("t4_unmask_src", 32'(exp_src), 32'b010);
        mask = 3'b010;
        tick(1);
        check("t4_remask_src", 32'(exp_src), 0);
        check("t4_remask_insvc", 32'(in_service), 0);
        check("t4_remask_pending", 32'(pending), 32'b010);
        push(3'b010, 2'd1);
        mask = 3'b000;
        tick(1);
        check("t4_again_src", 32'(exp_src), 32'b010);
        pulse_ack();
        pulse_eret();
        irq_in = 3'b000;
        tick(3);

        // Lost flag, lost_clr, and an edge coinciding with the ack.
        irq_in = 3'b001;
        push(3'b001, 2'd0);
        tick(4);
        irq_in = 3'b000;
        tick(3);
        irq_in = 3'b001;
        tick(3);
        check("t5_lost", 32'(lost), 32'b001);
        check("t5_pending", 32'(pending), 32'b001);
        lost_clr = 1'b1;
        tick(1);
        lost_clr = 1'b0;
        check("t5_lost_clr", 32'(lost), 0);
        irq_in = 3'b000;
        tick(3);
        irq_in = 3'b001;
        tick(2);
        pulse_ack();
        check("t5_coinc_pending", 32'(pending), 32'b001);
        check("t5_coinc_lost", 32'(lost), 0);
        check("t5_coinc_insvc", 32'(in_service), 1);
        push(3'b001, 2'd0);
        pulse_eret();
        check("t5_eret_src", 32'(exp_src), 0);
        tick(1);
        check("t5_re_src", 32'(exp_src), 32'b001);
        pulse_ack();
        check("t5_final_pending", 32'(pending), 0);
        pulse_eret();
        irq_in = 3'b000;
        tick(3);

        // Reset in REQ with the line still high: one fresh request afterwards.
        irq_in = 3'b001;
        push(3'b001, 2'd0);
        tick(4);
        check("t6_req_src", 32'(exp_src), 32'b001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_src", 32'(exp_src), 0);
        check("t6_rst_pending", 32'(pending), 0);
        check("t6_rst_insvc", 32'(in_service), 0);
        push(3'b001, 2'd0);
        tick(4);
        check("t6_post_src", 32'(exp_src), 32'b001);
        pulse_ack();
        pulse_eret();
        irq_in = 3'b000;
        tick(3);

        // Reset in SERVICE with irq_in[2] held high: exactly one more request.
        irq_in = 3'b100;
        push(3'b100, 2'd2);
        tick(4);
        pulse_ack();
        check("t7_insvc", 32'(in_service), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t7_rst_insvc", 32'(in_service), 0);
        check("t7_rst_src", 32'(exp_src), 0);
        check("t7_rst_cause", 32'(cause_id), 0);
        check("t7_rst_pending", 32'(pending), 0);
        push(3'b100, 2'd2);
        tick(4);
        check("t7_post_src", 32'(exp_src), 32'b100);
        pulse_ack();
        pulse_eret();
        tick(10);
        check("t7_no_second_src", 32'(exp_src), 0);
        check("t7_no_second_pending", 32'(pending), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_src_ctrl.md
# exp_src_ctrl

Upstream feeder for the CP0 exception unit. Synchronises external interrupt lines, detects rising edges, and latches them as pending. Selects one unmasked pending source by fixed priority and presents it to CP0 as a stable one-hot `exp_src` request. Tracks the serviced exception until ERET, so CP0 never sees a second request while a handler is running.

## Interface
- `NSRC`, 3: number of interrupt sources; matches CP0 `ExpSrc` width.
- `SYNC_STAGES`, 2: synchroniser depth per line (≥2).
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `irq_in`  in  NSRC: asynchronous interrupt lines, level; only rising edges count.
- `mask`  in  NSRC: 1 = source blocked (CP0 Block complement); pending is kept, not presented.
- `exp_ack`  in  1: one-cycle pulse when CP0 takes the exception.
- `eret`  in  1: one-cycle pulse when ERET retires.
- `lost_clr`  in  1: one-cycle pulse that clears `lost`.
- `exp_src`  out  NSRC: registered one-hot request to CP0; all-zero = none.
- `cause_id`  out  $clog2(NSRC): index of the source in `exp_src` or in service.
- `pending`  out  NSRC: latched, not-yet-acknowledged edges.
- `in_service`  out  1: handler active (state SERVICE).
- `lost`  out  NSRC: sticky; an edge arrived while that source was already pending.

## Operation
- Each line passes through an SYNC_STAGES flop chain, then a previous-value flop. `edge[i]` = sync & ~prev.
- `edge[i]` sets `pending[i]`. An edge on an already-pending source sets `lost[i]`.
- Winner: the highest set index of `pending & ~mask` (source NSRC-1 has the highest priority).
- FSM, encoded in the package:
  - **IDLE**
    - If any unmasked pending source: register the winner into `exp_src`/`cause_id`, go to REQ.
  - **REQ**
    - `exp_src` is held stable. A higher-priority edge does not pre-empt it.
    - On `exp_ack`: clear `pending[cause_id]`, zero `exp_src`, go to SERVICE; `cause_id` is retained.
    - If `mask[cause_id]` rises and there is no `exp_ack` that cycle: zero `exp_src`, go to IDLE; pending is retained.
  - **SERVICE**
    - `exp_src` stays 0. On `eret`, go to IDLE.
- Ignored pulses: `exp_ack` in IDLE/SERVICE; `eret` in IDLE/REQ.
- Simultaneous events:
  - Edge on source i in the same cycle `exp_ack` clears `pending[i]`: set wins, pending stays 1, `lost` not set.
  - `lost_clr` in the same cycle as a new lost event: set wins.
  - `exp_ack` and mask rise in the same cycle: ack wins.
  - `eret` in SERVICE with a pending unmasked source: go to IDLE, present it on the following cycle.
- Reset values: state IDLE; `exp_src`, `cause_id`, `pending`, `lost`, `in_service`, and all sync/prev flops = 0. A line held high across reset release yields exactly one edge.

## Timing
- `irq_in[i]` first sampled high at edge E:
  - `edge[i]` is true during the cycle after E+SYNC_STAGES−1.
  - `pending[i]` = 1 after E+SYNC_STAGES.
  - `exp_src[i]` = 1 after E+SYNC_STAGES+1, if IDLE and unmasked.
  - Total request latency: SYNC_STAGES+1 cycles (3 by default).
- `exp_ack` sampled at edge A: `exp_src` = 0 and `in_service` = 1 after A.
- `eret` at edge R: IDLE after R. The next request can appear after R+1.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `exp_pkg`:
  - NSRC default.
  - FSM state enum (IDLE/REQ/SERVICE).
  - Priority-select function returning the index plus a valid bit.
- Sub-module `irq_sync_edge`: one instance per source, with SYNC_STAGES chain, prev flop, and `edge` output; reset clears all flops.
- The top level holds pending/lost, the FSM, and the output registers.

## Test plan
- Rise `irq_in`=3'b001, mask=0 -> `exp_src`=001 and `cause_id`=0 exactly 3 cycles later. `exp_ack` -> `exp_src`=000, `in_service`=1, `pending`=000. `eret` -> `in_service`=0.
- `irq_in` 000→101 on the same edge -> `exp_src`=100. After ack+eret -> `exp_src`=001 on the cycle after eret+1.
- In REQ on source 0, pulse source 2 -> `exp_src` stays 001 until ack. Source 2 is presented only after eret.
- `mask`=010, rise source 1 -> `pending`=010, `exp_src`=000 indefinitely. Clear mask -> `exp_src`=010 next cycle. In REQ, set mask[1] -> `exp_src`=000, state IDLE, `pending`=010.
- Two edges on source 0 before ack -> `lost`=001. `lost_clr` -> 000. An edge coinciding with `exp_ack` for the same source -> `pending` stays 1, `lost`=000.
- Assert `rst` for 1 cycle in REQ and in SERVICE -> all outputs 0, IDLE. With `irq_in[2]` held high through reset -> one request on 100, no second one.
